// File: rtl/tas_pkg.sv
// rtl/tas_pkg.sv - shared types and helpers for the temperature averaging block
package tas_pkg;

  typedef enum logic [1:0] {HDR, TEMP, SKIP} parser_e;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} writer_e;

  localparam logic [7:0] HDR_A_DEF = 8'hA5;
  localparam logic [7:0] HDR_B_DEF = 8'hC3;

  // Divide-by-SAMPLES as a right shift; SAMPLES is a power of two.
  function automatic int avg_shift(input int samples);
    return $clog2(samples);
  endfunction

endpackage

// File: rtl/tas_deser.sv
// rtl/tas_deser.sv - LSB-first serial to parallel byte deserialiser with framing error pulse
module tas_deser #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              bit_i,
  input  logic              ena_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              byte_vld_o,
  output logic              frame_err_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              byte_vld_q;
  logic              frame_err_q;

  // After DATA_W right shifts the first bit received sits in bit 0.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q       <= '0;
      sh_q        <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (ena_i) begin
        sh_q <= {bit_i, sh_q[DATA_W-1:1]};
        if (cnt_q == CW'(DATA_W - 1)) begin
          cnt_q      <= '0;
          byte_vld_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (cnt_q != '0) begin
        cnt_q       <= '0;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign byte_o      = sh_q;
  assign byte_vld_o  = byte_vld_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/tas_avg_n.sv
// rtl/tas_avg_n.sv - packet parser, sample averager, one-entry holding register and RAM writer
module tas_avg_n
  import tas_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SAMPLES  = 4,
  parameter int                ADDR_W   = 11,
  parameter logic [DATA_W-1:0] HDR_A    = DATA_W'(HDR_A_DEF),
  parameter logic [DATA_W-1:0] HDR_B    = DATA_W'(HDR_B_DEF),
  parameter int                WR_PULSE = 2
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              frame_err
);

  localparam int SHIFT = avg_shift(SAMPLES);
  localparam int SW    = DATA_W + SHIFT;
  localparam int CW    = (SHIFT > 0) ? SHIFT : 1;

  logic [DATA_W-1:0] rx_byte;
  logic              byte_vld;

  tas_deser #(.DATA_W(DATA_W)) u_deser (
    .clk_i       (clk_50),
    .resetn_i    (reset_n),
    .bit_i       (serial_data),
    .ena_i       (data_ena),
    .byte_o      (rx_byte),
    .byte_vld_o  (byte_vld),
    .frame_err_o (frame_err)
  );

  parser_e           p_state_q, p_state_d;
  logic [CW-1:0]     pcnt_q, pcnt_d;
  logic [SW-1:0]     sum_q, sum_d, sum_acc;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  writer_e           w_state_q, w_state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, take;

  always_comb begin
    p_state_d  = p_state_q;
    pcnt_d     = pcnt_q;
    sum_d      = sum_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    w_state_d  = w_state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    push       = 1'b0;
    take       = 1'b0;
    sum_acc    = sum_q + SW'(rx_byte);

    // Header codes are only recognised in HDR; inside a payload they are data.
    if (byte_vld) begin
      unique case (p_state_q)
        HDR: begin
          pcnt_d    = '0;
          sum_d     = '0;
          p_state_d = (rx_byte == HDR_A || rx_byte == HDR_B) ? TEMP : SKIP;
        end
        TEMP: begin
          sum_d = sum_acc;
          if (pcnt_q == CW'(SAMPLES - 1)) begin
            push      = 1'b1;
            p_state_d = HDR;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        SKIP: begin
          if (pcnt_q == CW'(SAMPLES - 1)) p_state_d = HDR;
          else                           pcnt_d = pcnt_q + 1'b1;
        end
        default: p_state_d = HDR;
      endcase
    end

    unique case (w_state_q)
      IDLE: begin
        if (hold_vld_q) begin
          take      = 1'b1;
          data_d    = hold_q;
          w_state_d = SETUP;
        end
      end
      SETUP: begin
        wcnt_d    = '0;
        w_state_d = STROBE;
      end
      STROBE: begin
        if (wcnt_q == 2'(WR_PULSE - 1)) w_state_d = HOLD;
        else                           wcnt_d = wcnt_q + 1'b1;
      end
      HOLD: begin
        addr_d    = addr_q + 1'b1;
        w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase

    // A fresh average wins over the writer draining the holding register.
    if (push) begin
      hold_d     = DATA_W'(sum_acc >> SHIFT);
      hold_vld_d = 1'b1;
    end else if (take) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      p_state_q  <= HDR;
      pcnt_q     <= '0;
      sum_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      w_state_q  <= IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      p_state_q  <= p_state_d;
      pcnt_q     <= pcnt_d;
      sum_q      <= sum_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      w_state_q  <= w_state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign ram_wr_n = (w_state_q != STROBE);
  assign ram_addr = addr_q;
  assign ram_data = data_q;

endmodule

// File: tb/tb_tas_avg_n.sv
// tb/tb_tas_avg_n.sv - directed self-checking bench for tas_avg_n
module tb_tas_avg_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, serial_data, data_ena, sel8;
  logic ena_a, ena_b;
  assign ena_a = data_ena & ~sel8;
  assign ena_b = data_ena & sel8;

  logic       ram_wr_n, frame_err;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wr_n8, frame_err8;
  logic [3:0] ram_addr8;
  logic [7:0] ram_data8;

  tas_avg_n #(.ADDR_W(4)) dut (
    .clk_50(clk), .reset_n(reset_n), .serial_data(serial_data), .data_ena(ena_a),
    .ram_wr_n(ram_wr_n), .ram_addr(ram_addr), .ram_data(ram_data), .frame_err(frame_err)
  );

  tas_avg_n #(.SAMPLES(8), .ADDR_W(4)) dut8 (
    .clk_50(clk), .reset_n(reset_n), .serial_data(serial_data), .data_ena(ena_b),
    .ram_wr_n(ram_wr_n8), .ram_addr(ram_addr8), .ram_data(ram_data8), .frame_err(frame_err8)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       prev_wr = 1'b1;
  logic       prev_wr8 = 1'b1;
  int         nwr = 0, nwr8 = 0, lowcnt = 0, lastw = 0, nfe = 0;
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  logic [7:0] wd8[$];
  int         wfall[$];

  always @(negedge clk) begin
    if (prev_wr && !ram_wr_n) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
      wfall.push_back(cyc);
      nwr++;
      lowcnt = 1;
    end else if (!ram_wr_n) begin
      lowcnt++;
    end else if (!prev_wr) begin
      lastw = lowcnt;
    end
    prev_wr = ram_wr_n;
    if (prev_wr8 && !ram_wr_n8) begin
      wd8.push_back(ram_data8);
      nwr8++;
    end
    prev_wr8 = ram_wr_n8;
    if (frame_err) nfe++;
  end

  int last_cyc = 0;
  int base = 0;
  int fe0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) begin
      serial_data = b[i];
      data_ena    = 1'b1;
      @(negedge clk);
    end
    data_ena    = 1'b0;
    serial_data = 1'b0;
    last_cyc    = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      serial_data = b[i];
      data_ena    = 1'b1;
      @(negedge clk);
    end
    data_ena    = 1'b0;
    serial_data = 1'b0;
  endtask

  task automatic wait_wr(input int n);
    int t = 0;
    while (nwr < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("write_timeout", 32'(nwr >= n), 32'd1);
  endtask

  task automatic wait_wr8(input int n);
    int t = 0;
    while (nwr8 < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("write8_timeout", 32'(nwr8 >= n), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    serial_data = 1'b0;
    data_ena    = 1'b0;
    sel8        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_n", ram_wr_n, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_frame_err", frame_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // T1: one packet, latency and strobe width
    base = nwr;
    send_byte(8'hA5, 1); send_byte(8'h3A, 1); send_byte(8'h55, 1);
    send_byte(8'h43, 1); send_byte(8'h3C, 0);
    wait_wr(base + 1);
    chk("t1_data", wd[base], 67);
    chk("t1_addr", wa[base], 0);
    chk("t1_latency", wfall[base] - last_cyc, 3);
    repeat (6) @(negedge clk);
    chk("t1_strobe_width", lastw, 2);
    chk("t1_addr_incr", ram_addr, 1);
    chk("t1_data_stable", ram_data, 67);

    // T2: long idle gaps between bytes, then back-to-back burst
    do_reset();
    base = nwr;
    send_byte(8'hA5, 200); send_byte(8'h02, 200); send_byte(8'h04, 200);
    send_byte(8'h06, 200);
    chk("t2_no_early_write", nwr, base);
    send_byte(8'h08, 0); send_byte(8'hC3, 0); send_byte(8'h10, 0);
    send_byte(8'h12, 0); send_byte(8'h14, 0); send_byte(8'h16, 0);
    wait_wr(base + 2);
    chk("t2_data0", wd[base], 5);
    chk("t2_addr0", wa[base], 0);
    chk("t2_data1", wd[base+1], 8'h13);
    chk("t2_addr1", wa[base+1], 1);

    // T3: full-scale samples, SAMPLES=4 and SAMPLES=8
    do_reset();
    base = nwr;
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_byte(8'd127, 0);
    wait_wr(base + 1);
    chk("t3_avg127", wd[base], 127);
    sel8 = 1'b1;
    send_byte(8'hC3, 0);
    for (int i = 0; i < 8; i++) send_byte(8'd255, 0);
    wait_wr8(1);
    chk("t3_avg255_s8", wd8[0], 255);
    sel8 = 1'b0;
    @(negedge clk);

    // T4: skipped packet carrying header codes as payload
    do_reset();
    base = nwr;
    send_byte(8'h83, 1); send_byte(8'hA5, 1); send_byte(8'hC3, 1);
    send_byte(8'hA5, 1); send_byte(8'hC3, 1);
    send_byte(8'hA5, 1); send_byte(8'd18, 1); send_byte(8'd20, 1);
    send_byte(8'd22, 1); send_byte(8'd24, 1);
    wait_wr(base + 1);
    repeat (60) @(negedge clk);
    chk("t4_write_count", nwr, base + 1);
    chk("t4_data", wd[base], 21);

    // T5: partial byte inside payload
    do_reset();
    base = nwr;
    fe0  = nfe;
    send_byte(8'hA5, 1); send_byte(8'd10, 1);
    send_partial(8'hFF, 5);
    repeat (3) @(negedge clk);
    chk("t5_frame_err", nfe, fe0 + 1);
    send_byte(8'd20, 1); send_byte(8'd30, 1);
    repeat (20) @(negedge clk);
    chk("t5_no_write_yet", nwr, base);
    send_byte(8'd40, 1);
    wait_wr(base + 1);
    chk("t5_data", wd[base], 25);

    // T6: reset mid-strobe, then address wrap
    do_reset();
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) send_byte(8'd1, 0);
    for (int t = 0; t < 50 && ram_wr_n; t++) @(negedge clk);
    chk("t6_in_strobe", ram_wr_n, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_abort_wr_n", ram_wr_n, 1);
    chk("t6_abort_addr", ram_addr, 0);
    chk("t6_abort_data", ram_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    base = nwr;
    for (int k = 0; k < 16; k++) begin
      send_byte(8'hA5, 0);
      for (int i = 0; i < 4; i++) send_byte(8'(k), 0);
    end
    wait_wr(base + 16);
    chk("t6_addr15", wa[base+15], 15);
    chk("t6_data15", wd[base+15], 15);
    send_byte(8'hC3, 0);
    for (int i = 0; i < 4; i++) send_byte(8'd9, 0);
    wait_wr(base + 17);
    chk("t6_wrap_addr", wa[base+16], 0);
    chk("t6_wrap_data", wd[base+16], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
